// File: rtl/div_dispatcher_pkg.sv
// Shared definitions for the divider dispatcher: result status codes, FSM state
// encoding and the default operand width.
package div_dispatcher_pkg;

    localparam int unsigned DefWidth = 10;

    localparam logic [1:0] StatusOk      = 2'b00;
    localparam logic [1:0] StatusDvz     = 2'b01;
    localparam logic [1:0] StatusOvf     = 2'b10;
    localparam logic [1:0] StatusTimeout = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StOut,
        StRecover
    } state_e;

endpackage

// File: rtl/div_dispatcher_if.sv
// Bundle of the upstream, divider-side and downstream signals of the dispatcher.
// master is the dispatcher's view, slave is the surrounding environment's view.
interface div_dispatcher_if
    import div_dispatcher_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             div_start;
    logic             div_sclr;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             div_busy;
    logic             div_valid;
    logic             div_dvz;
    logic             div_ovf;
    logic [WIDTH-1:0] div_q;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       out_status;

    modport master (
        input  in_valid, in_a, in_b,
        input  div_busy, div_valid, div_dvz, div_ovf, div_q,
        input  out_ready,
        output in_ready,
        output div_start, div_sclr, div_a, div_b,
        output out_valid, out_q, out_status
    );

    modport slave (
        output in_valid, in_a, in_b,
        output div_busy, div_valid, div_dvz, div_ovf, div_q,
        output out_ready,
        input  in_ready,
        input  div_start, div_sclr, div_a, div_b,
        input  out_valid, out_q, out_status
    );

endinterface

// File: rtl/div_dispatcher_op_fifo.sv
// Operand-pair FIFO; DEPTH must be a power of two (>= 2) so pointers wrap naturally.
// A push while full is dropped even when a pop happens in the same cycle.
module op_fifo #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == FullCount);
    assign empty    = (count_q == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr_q] <= push_data;
                wr_ptr_q      <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/div_dispatcher.sv
// Queues operand pairs and feeds them one at a time to an external divider,
// with a watchdog that resets a hung divider and reports a timeout result.
module div_dispatcher
    import div_dispatcher_pkg::*;
#(
    parameter int unsigned WIDTH   = DefWidth,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 63
) (
    input logic              clk,
    input logic              sclr,
    div_dispatcher_if.master bus
);

    localparam int unsigned WdWidth = $clog2(TIMEOUT + 1);
    localparam logic [WdWidth-1:0] WdMax = WdWidth'(TIMEOUT);

    state_e               state_q, state_d;
    logic [WdWidth-1:0]   wd_q, wd_d, wd_now;
    logic [WIDTH-1:0]     a_q, b_q;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [1:0]           status_q, status_d;
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [2*WIDTH-1:0]   fifo_head;
    logic                 start, recover, out_valid;

    op_fifo #(
        .WIDTH(2 * WIDTH),
        .DEPTH(DEPTH)
    ) u_op_fifo (
        .clk      (clk),
        .sclr     (sclr),
        .push     (bus.in_valid),
        .push_data({bus.in_a, bus.in_b}),
        .pop      (fifo_pop),
        .pop_data (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        q_d       = q_q;
        status_d  = status_q;
        fifo_pop  = 1'b0;
        start     = 1'b0;
        recover   = 1'b0;
        out_valid = 1'b0;
        // Watchdog value counting the current WAIT cycle, saturating at TIMEOUT.
        wd_now    = (wd_q == WdMax) ? wd_q : wd_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && !bus.div_busy) begin
                    fifo_pop = 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                start   = 1'b1;
                wd_d    = '0;
                state_d = StWait;
            end
            StWait: begin
                wd_d = wd_now;
                if (bus.div_dvz) begin
                    q_d      = '0;
                    status_d = StatusDvz;
                    state_d  = StOut;
                end else if (bus.div_ovf) begin
                    q_d      = '0;
                    status_d = StatusOvf;
                    state_d  = StOut;
                end else if (bus.div_valid) begin
                    q_d      = bus.div_q;
                    status_d = StatusOk;
                    state_d  = StOut;
                end else if (wd_now == WdMax) begin
                    q_d      = '0;
                    status_d = StatusTimeout;
                    state_d  = StRecover;
                end
            end
            StRecover: begin
                recover = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q  <= StIdle;
            wd_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            q_q      <= '0;
            status_q <= StatusOk;
        end else begin
            state_q  <= state_d;
            wd_q     <= wd_d;
            q_q      <= q_d;
            status_q <= status_d;
            if (fifo_pop) begin
                {a_q, b_q} <= fifo_head;
            end
        end
    end

    assign bus.in_ready   = ~fifo_full;
    assign bus.div_start  = start;
    assign bus.div_sclr   = recover;
    assign bus.div_a      = a_q;
    assign bus.div_b      = b_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_q      = q_q;
    assign bus.out_status = status_q;

endmodule

// File: tb/tb_div_dispatcher.sv
// Directed bench for div_dispatcher with a behavioural divider and a result scoreboard.
module tb_div_dispatcher;

    localparam int unsigned W = 10;
    localparam int unsigned D = 4;
    localparam int unsigned T = 63;

    logic clk = 1'b0;
    logic sclr;
    always #5 clk = ~clk;

    div_dispatcher_if #(.WIDTH(W)) bus ();

    div_dispatcher #(
        .WIDTH  (W),
        .DEPTH  (D),
        .TIMEOUT(T)
    ) u_dut (
        .clk (clk),
        .sclr(sclr),
        .bus (bus)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    logic [W+1:0] exp_q [$];  // {status, quotient} in push order

    // Divider model: 0 normal, 1 never answers, 2 dvz+ovf+valid together, 3 ovf+valid.
    int unsigned model_mode = 0;
    int unsigned model_lat  = 20;
    logic        running;
    int unsigned lat_cnt;
    logic [W-1:0] ma, mb;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        bus.div_valid <= 1'b0;
        bus.div_dvz   <= 1'b0;
        bus.div_ovf   <= 1'b0;
        bus.div_q     <= '0;
        if (sclr || bus.div_sclr) begin
            running      <= 1'b0;
            bus.div_busy <= 1'b0;
            lat_cnt      <= 0;
        end else if (bus.div_start) begin
            running      <= 1'b1;
            bus.div_busy <= 1'b1;
            lat_cnt      <= 0;
            ma           <= bus.div_a;
            mb           <= bus.div_b;
        end else if (running && model_mode != 1) begin
            if (lat_cnt + 1 >= model_lat) begin
                running      <= 1'b0;
                bus.div_busy <= 1'b0;
                case (model_mode)
                    2: begin
                        bus.div_dvz   <= 1'b1;
                        bus.div_ovf   <= 1'b1;
                        bus.div_valid <= 1'b1;
                        bus.div_q     <= ma / mb;
                    end
                    3: begin
                        bus.div_ovf   <= 1'b1;
                        bus.div_valid <= 1'b1;
                        bus.div_q     <= ma / mb;
                    end
                    default: begin
                        if (mb == '0) begin
                            bus.div_dvz <= 1'b1;
                        end else begin
                            bus.div_valid <= 1'b1;
                            bus.div_q     <= ma / mb;
                        end
                    end
                endcase
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W+1:0] exp, output int unsigned edge_no);
        bit acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        for (int i = 0; i < 300 && !acc; i++) begin
            acc = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        edge_no      = cyc;
        if (acc) exp_q.push_back(exp);
        chk("push_accept", 32'(acc), 1);
    endtask

    task automatic wait_start(input string tag, output int unsigned c);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.div_start) seen = 1'b1;
            else tick();
        end
        chk({tag, "_start_seen"}, 32'(seen), 1);
        c = cyc;
    endtask

    task automatic check_result(input string tag);
        logic [W+1:0] e;
        chk({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({tag, "_q"}, 32'(bus.out_q), 32'(e[W-1:0]));
            chk({tag, "_status"}, 32'(bus.out_status), 32'(e[W+1:W]));
        end
    endtask

    task automatic take(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else tick();
        end
        chk({tag, "_out_seen"}, 32'(seen), 1);
        if (seen) begin
            check_result(tag);
            bus.out_ready = 1'b1;
            tick();
            chk({tag, "_idle_after"}, 32'(bus.out_valid), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int unsigned p, s, cr, hits;
        logic [W+1:0] e;
        logic [W-1:0] a, b;
        bit seen;

        sclr          = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        sclr = 1'b0;

        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_div_start", 32'(bus.div_start), 0);
        chk("rst_div_sclr", 32'(bus.div_sclr), 0);
        chk("rst_div_a", 32'(bus.div_a), 0);
        chk("rst_div_b", 32'(bus.div_b), 0);
        chk("rst_out_q", 32'(bus.out_q), 0);
        chk("rst_out_status", 32'(bus.out_status), 0);

        // Single job: start is captured by the divider two edges after acceptance.
        bus.out_ready = 1'b1;
        push(10'd100, 10'd7, {2'b00, 10'd14}, p);
        wait_start("t1", s);
        chk("t1_start_latency", (s + 1) - p, 2);
        chk("t1_div_a", 32'(bus.div_a), 100);
        chk("t1_div_b", 32'(bus.div_b), 7);
        take("t1");
        chk("t1_div_a_held", 32'(bus.div_a), 100);

        // Divide by zero.
        push(10'd5, 10'd0, {2'b01, 10'd0}, p);
        take("t2_dvz");

        // Full FIFO with the output stalled.
        model_lat     = 5;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            a = W'(40 + 30 * i);
            b = W'(3 + i);
            push(a, b, {2'b00, a / b}, p);
        end
        chk("t3_full", 32'(bus.in_ready), 0);
        bus.in_valid = 1'b1;
        bus.in_a     = 10'd500;
        bus.in_b     = 10'd9;
        repeat (10) tick();
        bus.in_valid = 1'b0;
        chk("t3_still_full", 32'(bus.in_ready), 0);
        chk("t3_out_held", 32'(bus.out_valid), 1);
        e = exp_q[0];
        chk("t3_hold_q0", 32'(bus.out_q), 32'(e[W-1:0]));
        repeat (3) tick();
        chk("t3_hold_q1", 32'(bus.out_q), 32'(e[W-1:0]));
        chk("t3_hold_status", 32'(bus.out_status), 0);
        take("t3_r0");
        push(10'd500, 10'd9, {2'b00, 10'd55}, p);
        for (int i = 1; i < 6; i++) take($sformatf("t3_r%0d", i));

        // Simultaneous push and pop with two entries queued.
        model_lat     = 20;
        bus.out_ready = 1'b0;
        push(10'd60, 10'd6, {2'b00, 10'd10}, p);
        push(10'd70, 10'd7, {2'b00, 10'd10}, p);
        push(10'd80, 10'd8, {2'b00, 10'd10}, p);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus.out_valid) seen = 1'b1;
            else tick();
        end
        chk("t4_a_seen", 32'(seen), 1);
        check_result("t4_a");
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 10'd90;
        bus.in_b      = 10'd9;
        chk("t4_ready_at_2", 32'(bus.in_ready), 1);
        exp_q.push_back({2'b00, 10'd10});
        tick();
        bus.in_valid = 1'b0;
        push(10'd33, 10'd3, {2'b00, 10'd11}, p);
        chk("t4_count3_ready", 32'(bus.in_ready), 1);
        push(10'd44, 10'd4, {2'b00, 10'd11}, p);
        chk("t4_count4_full", 32'(bus.in_ready), 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) take($sformatf("t4_r%0d", i));

        // Watchdog timeout with a silent divider.
        model_mode = 1;
        push(10'd9, 10'd3, {2'b11, 10'd0}, p);
        wait_start("t5", s);
        tick();
        seen = 1'b0;
        for (int i = 0; i < T + 20 && !seen; i++) begin
            if (bus.div_sclr) seen = 1'b1;
            else tick();
        end
        cr = cyc;
        chk("t5_sclr_seen", 32'(seen), 1);
        chk("t5_sclr_delay", cr - s, T + 1);
        tick();
        chk("t5_sclr_one_cycle", 32'(bus.div_sclr), 0);
        take("t5_timeout");
        model_mode = 0;

        // Reset while waiting on the divider abandons the job.
        push(10'd50, 10'd5, {2'b00, 10'd10}, p);
        wait_start("t6", s);
        repeat (5) tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        exp_q.delete();
        chk("t6_out_valid", 32'(bus.out_valid), 0);
        chk("t6_in_ready", 32'(bus.in_ready), 1);
        chk("t6_div_a", 32'(bus.div_a), 0);
        hits = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid || bus.div_start) hits++;
            tick();
        end
        chk("t6_quiet", hits, 0);
        push(10'd77, 10'd7, {2'b00, 10'd11}, p);
        take("t6_after");

        // Done-pulse priority.
        model_lat  = 4;
        model_mode = 2;
        push(10'd20, 10'd4, {2'b01, 10'd0}, p);
        take("t7_dvz_wins");
        model_mode = 3;
        push(10'd21, 10'd3, {2'b10, 10'd0}, p);
        take("t7_ovf_wins");
        model_mode = 0;

        chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
